// File: rtl/msi_cache_dm.sv
// Direct-mapped write-back cache with MSI snooping for a two-CPU coherent system.
// Handshakes: cpu_req, mem_req, bus_valid and snp_valid are level requests held by their source until the matching done/ack pulse.
module msi_cache_dm #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LINES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_valid,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_ack,
  input  logic              snp_valid,
  input  logic [1:0]        snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              snp_ack,
  output logic [1:0]        err,
  output logic [2:0]        fsm_state
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RM   = 2'd1;
  localparam logic [1:0] OP_WM   = 2'd2;
  localparam logic [1:0] OP_INV  = 2'd3;

  typedef enum logic [1:0] {L_I, L_S, L_M} line_t;
  typedef enum logic [2:0] {IDLE, SNP_WB, WB, BCAST, FILL, ERR} state_t;

  line_t             line_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  state_t            state_q, state_d, ret_q, ret_d;
  logic [1:0]        op_q, op_d, err_q, err_d;
  logic              pend_q, pend_d, done_q, done_d;
  logic              s1_q, s1_d, ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              line_we, arr_we;
  logic [IDX_W-1:0]  line_idx, arr_idx;
  line_t             line_val;
  logic [TAG_W-1:0]  arr_tag;
  logic [DATA_W-1:0] arr_data;

  logic [IDX_W-1:0] cpu_idx, snp_idx;
  logic [TAG_W-1:0] cpu_tag, snp_tag;
  line_t            cpu_line, snp_line;
  logic             cpu_hit, snp_hit, snp_busy, serve;

  assign cpu_idx  = cpu_addr[IDX_W-1:0];
  assign cpu_tag  = cpu_addr[ADDR_W-1:IDX_W];
  assign snp_idx  = snp_addr[IDX_W-1:0];
  assign snp_tag  = snp_addr[ADDR_W-1:IDX_W];
  assign cpu_line = line_q[cpu_idx];
  assign snp_line = line_q[snp_idx];
  assign cpu_hit  = (cpu_line != L_I) && (tag_q[cpu_idx] == cpu_tag);
  assign snp_hit  = (snp_line != L_I) && (tag_q[snp_idx] == snp_tag);
  // A snoop stays blocked from acceptance until its ack has gone out, since the peer holds snp_valid until then.
  assign snp_busy = s1_q | ack_q;
  assign serve    = snp_valid && !snp_busy && !done_q && (state_q == IDLE || state_q == BCAST);

  assign cpu_done  = done_q;
  assign cpu_rdata = rdata_q;
  assign snp_ack   = ack_q;
  assign err       = err_q;
  assign fsm_state = state_q;
  assign bus_valid = pend_q && (state_q != ERR);
  assign bus_op    = bus_valid ? op_q : OP_NONE;
  assign bus_addr  = bus_valid ? cpu_addr : '0;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    op_d      = op_q;
    pend_d    = pend_q && !bus_ack;
    err_d     = err_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    s1_d      = 1'b0;
    ack_d     = s1_q;
    line_we   = 1'b0;
    line_idx  = cpu_idx;
    line_val  = L_I;
    arr_we    = 1'b0;
    arr_idx   = cpu_idx;
    arr_tag   = cpu_tag;
    arr_data  = cpu_wdata;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (serve) begin
      if (snp_op == OP_NONE) begin
        err_d   = 2'd2;
        state_d = ERR;
      end else if (snp_hit && snp_line == L_M && snp_op != OP_INV) begin
        ret_d   = state_q;
        state_d = SNP_WB;
      end else begin
        s1_d = 1'b1;
        if (snp_hit && snp_line == L_S && snp_op != OP_RM) begin
          line_we  = 1'b1;
          line_idx = snp_idx;
          line_val = L_I;
          // Losing the shared copy mid-upgrade turns the INV into a full write miss.
          if (state_q == BCAST && op_q == OP_INV && snp_idx == cpu_idx) begin
            op_d   = OP_WM;
            pend_d = 1'b1;
          end
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req && !done_q && !snp_busy && !snp_valid) begin
            if (cpu_hit) begin
              if (!cpu_we) begin
                rdata_d = data_q[cpu_idx];
                done_d  = 1'b1;
              end else if (cpu_line == L_M) begin
                arr_we = 1'b1;
                done_d = 1'b1;
              end else begin
                op_d    = OP_INV;
                pend_d  = 1'b1;
                state_d = BCAST;
              end
            end else if (cpu_line == L_M) begin
              state_d = WB;
            end else begin
              op_d    = cpu_we ? OP_WM : OP_RM;
              pend_d  = 1'b1;
              state_d = BCAST;
            end
          end
        end
        WB: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {tag_q[cpu_idx], cpu_idx};
          mem_wdata = data_q[cpu_idx];
          if (mem_done) begin
            line_we  = 1'b1;
            line_val = L_I;
            op_d     = cpu_we ? OP_WM : OP_RM;
            pend_d   = 1'b1;
            state_d  = BCAST;
          end
        end
        SNP_WB: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = snp_addr;
          mem_wdata = data_q[snp_idx];
          if (mem_done) begin
            line_we  = 1'b1;
            line_idx = snp_idx;
            line_val = (snp_op == OP_RM) ? L_S : L_I;
            ack_d    = 1'b1;
            state_d  = ret_q;
          end
        end
        BCAST: begin
          if (!pend_q && !snp_busy && !snp_valid) begin
            if (op_q == OP_INV) begin
              arr_we   = 1'b1;
              line_we  = 1'b1;
              line_val = L_M;
              done_d   = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = FILL;
            end
          end
        end
        FILL: begin
          mem_req  = 1'b1;
          mem_addr = cpu_addr;
          if (mem_done) begin
            arr_we   = 1'b1;
            arr_data = cpu_we ? cpu_wdata : mem_rdata;
            line_we  = 1'b1;
            line_val = cpu_we ? L_M : L_S;
            rdata_d  = mem_rdata;
            done_d   = 1'b1;
            state_d  = IDLE;
          end
        end
        default: ;
      endcase
    end
    if (state_q != ERR && mem_done && !mem_req) begin
      err_d   = 2'd1;
      state_d = ERR;
    end
    if (state_d == ERR) begin
      line_we = 1'b0;
      arr_we  = 1'b0;
      done_d  = 1'b0;
      s1_d    = 1'b0;
      ack_d   = 1'b0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LINES; i++) line_q[i] <= L_I;
      state_q <= IDLE;
      ret_q   <= IDLE;
      op_q    <= OP_NONE;
      err_q   <= 2'd0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      s1_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      op_q    <= op_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      s1_q    <= s1_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      if (line_we) line_q[line_idx] <= line_val;
    end
  end

  // Tag and data storage is left uninitialised; the line state alone says what is valid.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_q[arr_idx]  <= arr_tag;
      data_q[arr_idx] <= arr_data;
    end
  end
endmodule
